volume_bar_renderer: RTL
========================

Name: volume_bar_renderer

Overview:
Downstream consumer of the theme colour selector's five RGB565 colours: background, frame, and the low, mid and high bar bands. Per OLED pixel, it produces the 96x64 display pixel for a framed vertical volume meter. The meter has a smoothed bar level and a peak-hold marker, both updated once per OLED frame. Sits between the colour selector / volume-level source and the OLED driver.

Parameters:
HOLD_FRAMES, 30, frames the peak marker is held before it starts decaying
DECAY_FRAMES, 4, frames per one-segment decay step for bar and peak
BAR_X0, 40, leftmost column of the bar
BAR_W, 16, bar width in columns

Ports:
clock  in  1  system clock (OLED pixel clock domain)
reset  in  1  asynchronous, active-high reset
frame_begin  in  1  one-cycle pulse from the OLED driver at the start of each frame
pixel_index  in  13  current pixel, 0..6143; x = idx mod 96, y = idx div 96
level  in  4  instantaneous volume level, 0..15
frame_en  in  1  1 = draw the 1-pixel border
bg_col  in  16  background colour
frame_col  in  16  border and peak-marker colour
low_col  in  16  colour of segments 1-5
mid_col  in  16  colour of segments 6-10
high_col  in  16  colour of segments 11-15
pixel_data  out  16  registered RGB565 pixel to the OLED driver
disp_level  out  4  current smoothed bar level
peak_level  out  4  current peak-marker level

Behaviour:
- Reset (asynchronous, immediate): the following all go to 0.
  - pixel_data, disp_level, peak_level
  - hold counter, decay counter
- State updates only on cycles with frame_begin=1. All other cycles hold state.
- Decay counter runs 0..DECAY_FRAMES-1 and wraps. tick = (decay counter == DECAY_FRAMES-1) on a frame_begin cycle. The counter increments on every frame_begin.
- Bar level update on frame_begin (new value d'):
  - if level >= disp_level: d' = level (instant rise)
  - else if tick and disp_level > 0: d' = disp_level-1
  - else hold
- Peak update on the same frame_begin:
  - if level >= peak_level: peak_level <= level, hold <= 0
  - else if hold < HOLD_FRAMES: hold <= hold+1
  - else if tick and peak_level > d': peak_level <= peak_level-1
  - Invariant peak_level >= disp_level holds at all times. The verifier asserts it.
- Bar geometry: segment k (1..15) occupies rows 63-4k .. 65-4k (3 rows), columns BAR_X0 .. BAR_X0+BAR_W-1. Row 66-4k is the gap row (background). Rows 1-2 are always background.
- Pixel colour priority (highest first):
  1. pixel_index >= 6144 -> bg_col
  2. frame_en and (x==0 or x==95 or y==0 or y==63) -> frame_col
  3. inside segment k with k <= disp_level -> band colour by k: low 1-5, mid 6-10, high 11-15
  4. inside segment k with k == peak_level and peak_level > disp_level -> frame_col
  5. otherwise -> bg_col
- Latency: pixel_data is registered, one clock after pixel_index/colour inputs. The pixel rendered on the frame_begin cycle already uses the pre-update levels. The new levels apply from the next cycle.
- Colour inputs may change at any time and take effect on the next pixel. Level 0 draws no segments and no marker.
- Reset mid-frame: the output is forced to 0 immediately. Rendering resumes on the next cycle after release, with levels 0.
- x/y are derived without a general divider: compare/subtract chain or a registered row counter. The result must match idx mod 96 and idx div 96 exactly.

Decomposition:
- Shared package (oled_pkg) holds:
  - OLED_W=96, OLED_H=64, NUM_PIX=6144
  - NUM_SEG=15, SEG_PITCH=4, SEG_H=3
  - band thresholds LOW_MAX=5, MID_MAX=10
  - RGB565 colour type
- One sub-module: bar_level_tracker. It holds disp_level, peak_level and the hold/decay counters, with inputs clock, reset, frame_begin, level.
- Pixel mapping and colour mux stay in the top module.

Test Plan:
1. Reset, then colours {bg=0000, frame=FFFF, low=07E0, mid=FFE0, high=F800}, frame_en=1, level=7, one frame_begin -> disp=7, peak=7. Then:
   - idx 96*56+40 (segment 2) -> 07E0
   - idx 96*36+45 (segment 7) -> FFE0
   - idx 96*32+40 (segment 8) -> 0000
   - idx 5 (border) -> FFFF
2. Level 15 for one frame, then level 0 -> disp decays 15->14 on the next tick frame and 1 per 4 frames after. Peak stays 15 for 30 frames, then decays 1 per 4 frames while > disp. peak>=disp every frame.
3. Peak=12, disp=3 -> idx 96*17+50 (segment 12) outputs frame_col FFFF. Row 96*18+50 (gap row) outputs bg_col.
4. frame_en=0 -> idx 0 and idx 6143 output bg_col. idx 6200 -> bg_col.
5. Assert reset mid-frame with disp=9 -> pixel_data=0000 same cycle. After release, disp=peak=0 and bar pixels show bg_col.
6. Change low_col 07E0->001F mid-frame -> the next segment-1 pixel outputs 001F, exactly one cycle after its pixel_index.

Source files
------------

// File: rtl/volume_bar_renderer_pkg.sv
// Shared OLED geometry, colour type and pixel-coordinate helpers for the
// volume meter renderer.
package oled_pkg;

  localparam int OLED_W    = 96;
  localparam int OLED_H    = 64;
  localparam int NUM_PIX   = 6144;
  localparam int NUM_SEG   = 15;
  localparam int SEG_PITCH = 4;
  localparam int SEG_H     = 3;
  localparam int LOW_MAX   = 5;
  localparam int MID_MAX   = 10;

  typedef logic [15:0] rgb565_t;

  typedef enum logic [1:0] {
    BAND_LOW  = 2'd0,
    BAND_MID  = 2'd1,
    BAND_HIGH = 2'd2,
    BAND_NONE = 2'd3
  } band_e;

  typedef struct packed {
    logic [6:0] x;
    logic [5:0] y;
  } pix_xy_t;

  // Restoring-division chain against 96<<i; exact for idx < NUM_PIX.
  function automatic pix_xy_t pix_to_xy(input logic [12:0] idx);
    logic [12:0] rem_v;
    pix_xy_t     r;
    rem_v = idx;
    r     = '0;
    for (int i = 5; i >= 0; i--) begin
      if (rem_v >= (13'(OLED_W) << i)) begin
        rem_v  = rem_v - (13'(OLED_W) << i);
        r.y[i] = 1'b1;
      end else begin
        rem_v = rem_v;
      end
    end
    r.x = rem_v[6:0];
    return r;
  endfunction

  // Segment k covers rows 63-4k..65-4k, so u = 66-y gives k = u/4 with a
  // non-zero remainder; remainder 0 is the gap row. Returns 0 for no segment.
  function automatic logic [3:0] seg_of_row(input logic [5:0] y);
    logic [6:0] u;
    u = 7'd66 - {1'b0, y};
    if ((u[1:0] != 2'd0) && (u[6:2] >= 5'd1) && (u[6:2] <= 5'(NUM_SEG))) begin
      return u[5:2];
    end else begin
      return 4'd0;
    end
  endfunction

  function automatic band_e band_of(input logic [3:0] seg);
    if (seg == 4'd0) begin
      return BAND_NONE;
    end else if (seg <= 4'(LOW_MAX)) begin
      return BAND_LOW;
    end else if (seg <= 4'(MID_MAX)) begin
      return BAND_MID;
    end else begin
      return BAND_HIGH;
    end
  endfunction

endpackage

// File: rtl/volume_bar_renderer_if.sv
// Pixel-stream bundle between the OLED driver side and the volume bar renderer.
interface volume_bar_renderer_if;

  logic               frame_begin;
  logic [12:0]        pixel_index;
  logic [3:0]         level;
  logic               frame_en;
  oled_pkg::rgb565_t  bg_col;
  oled_pkg::rgb565_t  frame_col;
  oled_pkg::rgb565_t  low_col;
  oled_pkg::rgb565_t  mid_col;
  oled_pkg::rgb565_t  high_col;
  oled_pkg::rgb565_t  pixel_data;
  logic [3:0]         disp_level;
  logic [3:0]         peak_level;

  modport master (
    output frame_begin, pixel_index, level, frame_en,
    output bg_col, frame_col, low_col, mid_col, high_col,
    input  pixel_data, disp_level, peak_level
  );

  modport slave (
    input  frame_begin, pixel_index, level, frame_en,
    input  bg_col, frame_col, low_col, mid_col, high_col,
    output pixel_data, disp_level, peak_level
  );

endinterface

// File: rtl/volume_bar_renderer_bar_level_tracker.sv
// Smoothed bar level and peak-hold marker, both advanced once per OLED frame.
module bar_level_tracker
  import oled_pkg::*;
#(
  parameter int HOLD_FRAMES  = 30,
  parameter int DECAY_FRAMES = 4
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       frame_begin,
  input  logic [3:0] level,
  output logic [3:0] disp_level,
  output logic [3:0] peak_level
);

  localparam int HOLD_W = $clog2(HOLD_FRAMES + 1);
  localparam int DEC_W  = (DECAY_FRAMES > 1) ? $clog2(DECAY_FRAMES) : 1;

  logic [3:0]        disp_r;
  logic [3:0]        peak_r;
  logic [HOLD_W-1:0] hold_r;
  logic [DEC_W-1:0]  decay_r;
  logic              tick_s;
  logic [3:0]        disp_next_s;

  // Decay tick and next bar level; the peak decision compares against it.
  always_comb begin
    tick_s      = (decay_r == DEC_W'(DECAY_FRAMES - 1));
    disp_next_s = disp_r;
    if (level >= disp_r) begin
      disp_next_s = level;
    end else if (tick_s && (disp_r != 4'd0)) begin
      disp_next_s = disp_r - 4'd1;
    end else begin
      disp_next_s = disp_r;
    end
  end

  // Per-frame state update; all other cycles hold.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      disp_r  <= 4'd0;
      peak_r  <= 4'd0;
      hold_r  <= '0;
      decay_r <= '0;
    end else if (frame_begin) begin
      disp_r  <= disp_next_s;
      decay_r <= tick_s ? '0 : decay_r + DEC_W'(1);
      if (level >= peak_r) begin
        peak_r <= level;
        hold_r <= '0;
      end else if (hold_r < HOLD_W'(HOLD_FRAMES)) begin
        hold_r <= hold_r + HOLD_W'(1);
      end else if (tick_s && (peak_r > disp_next_s)) begin
        peak_r <= peak_r - 4'd1;
      end
    end
  end

  assign disp_level = disp_r;
  assign peak_level = peak_r;

endmodule

// File: rtl/volume_bar_renderer.sv
// Renders a framed vertical volume meter with peak marker into the 96x64
// OLED pixel stream, one registered RGB565 pixel per clock.
module volume_bar_renderer
  import oled_pkg::*;
#(
  parameter int HOLD_FRAMES  = 30,
  parameter int DECAY_FRAMES = 4,
  parameter int BAR_X0       = 40,
  parameter int BAR_W        = 16
) (
  input  logic                  clock,
  input  logic                  reset,
  volume_bar_renderer_if.slave  bus
);

  logic [3:0] disp_s;
  logic [3:0] peak_s;
  pix_xy_t    xy_s;
  logic [3:0] seg_s;
  logic       in_col_s;
  logic       border_s;
  rgb565_t    band_col_s;
  rgb565_t    pix_next_s;
  rgb565_t    pix_r;

  bar_level_tracker #(
    .HOLD_FRAMES  (HOLD_FRAMES),
    .DECAY_FRAMES (DECAY_FRAMES)
  ) u_tracker (
    .clock       (clock),
    .reset       (reset),
    .frame_begin (bus.frame_begin),
    .level       (bus.level),
    .disp_level  (disp_s),
    .peak_level  (peak_s)
  );

  // Pixel position, segment decode and band colour for the current index.
  always_comb begin
    xy_s     = pix_to_xy(bus.pixel_index);
    seg_s    = seg_of_row(xy_s.y);
    in_col_s = (xy_s.x >= 7'(BAR_X0)) && (xy_s.x <= 7'(BAR_X0 + BAR_W - 1));
    border_s = bus.frame_en &&
               ((xy_s.x == 7'd0) || (xy_s.x == 7'(OLED_W - 1)) ||
                (xy_s.y == 6'd0) || (xy_s.y == 6'(OLED_H - 1)));
    case (band_of(seg_s))
      BAND_LOW:  band_col_s = bus.low_col;
      BAND_MID:  band_col_s = bus.mid_col;
      BAND_HIGH: band_col_s = bus.high_col;
      default:   band_col_s = bus.bg_col;
    endcase
  end

  // Colour priority: off-screen, border, lit segment, peak marker, background.
  always_comb begin
    pix_next_s = bus.bg_col;
    if (bus.pixel_index >= 13'(NUM_PIX)) begin
      pix_next_s = bus.bg_col;
    end else if (border_s) begin
      pix_next_s = bus.frame_col;
    end else if (in_col_s && (seg_s != 4'd0) && (seg_s <= disp_s)) begin
      pix_next_s = band_col_s;
    end else if (in_col_s && (seg_s != 4'd0) && (seg_s == peak_s) && (peak_s > disp_s)) begin
      pix_next_s = bus.frame_col;
    end else begin
      pix_next_s = bus.bg_col;
    end
  end

  // Output pixel register; uses levels as they stood before this edge.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pix_r <= 16'h0000;
    end else begin
      pix_r <= pix_next_s;
    end
  end

  assign bus.pixel_data = pix_r;
  assign bus.disp_level = disp_s;
  assign bus.peak_level = peak_s;

endmodule
